// File: rtl/find_min.sv
// Signed minimum of N packed W-bit elements, scanned one element per cycle.
// Latency N edges from the start-sampling edge; no backpressure: start is a held level, dropping it aborts.
module find_min #(
    parameter int N = 8,
    parameter int W = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N*W-1:0] numbers,
    output logic           done,
    output logic [W-1:0]   result
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        SCAN,
        DONE
    } state_t;

    state_t          state_q;
    logic [W-1:0]    min_q;
    logic [W-1:0]    result_q;
    logic [IW-1:0]   idx_q;
    logic            done_q;

    logic [W-1:0]    elem_cur;
    logic [W-1:0]    min_d;

    // Strict less-than keeps the earlier element on ties.
    always_comb begin
        elem_cur = numbers[W*idx_q +: W];
        min_d    = ($signed(elem_cur) < $signed(min_q)) ? elem_cur : min_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            min_q    <= '0;
            result_q <= '0;
            idx_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= INIT;
                    end
                end
                INIT: begin
                    if (!start) begin
                        state_q <= IDLE;
                    end else begin
                        min_q   <= numbers[W-1:0];
                        idx_q   <= IW'(1);
                        state_q <= SCAN;
                    end
                end
                SCAN: begin
                    if (!start) begin
                        state_q <= IDLE;
                    end else begin
                        min_q <= min_d;
                        if (idx_q == LAST) begin
                            result_q <= min_d;
                            done_q   <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            idx_q <= idx_q + IW'(1);
                        end
                    end
                end
                DONE: begin
                    if (!start) begin
                        done_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_find_min.sv
// Scoreboard bench for find_min: stimulus pushes expected minimum and done cycle, a negedge monitor pops on done rise.
module tb_find_min;
    localparam int N = 8;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [N*W-1:0] numbers = '0;
    logic           done;
    logic [W-1:0]   result;

    always #5 clk = ~clk;

    find_min #(.N(N), .W(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .numbers (numbers),
        .done    (done),
        .result  (result)
    );

    typedef struct {
        logic [W-1:0] res;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares on every done rise, and checks result holds while done stays high.
    logic         prev_done = 1'b0;
    logic [W-1:0] prev_res = '0;
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (done && !prev_done) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got done=1 result=%h expected done=0", result);
                end else begin
                    e = sb.pop_front();
                    check("result", 32'(result), 32'(e.res));
                    check("latency_cycle", 32'(cyc), 32'(e.cyc));
                end
            end else if (done && prev_done) begin
                check("result_hold", 32'(result), 32'(prev_res));
            end
        end
        prev_done = done;
        prev_res  = result;
    end

    // Called at a negedge; start is sampled on the next edge k, done expected after edge k+N.
    task automatic issue(input logic [N*W-1:0] v, input logic [W-1:0] exp_res);
        exp_t e;
        numbers = v;
        start   = 1'b1;
        e.res   = exp_res;
        e.cyc   = cyc + 1 + N;
        sb.push_back(e);
    endtask

    task automatic finish_op(input logic [W-1:0] exp_res, input int hold);
        int t;
        t = 0;
        while (!done && t < 30) begin
            @(negedge clk);
            t++;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got done=0 expected done=1 within 30 cycles");
        end
        repeat (hold) @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("done_drop", 32'(done), 32'd0);
        check("result_kept", 32'(result), 32'(exp_res));
    endtask

    task automatic run_op(input logic [N*W-1:0] v, input logic [W-1:0] exp_res, input int hold);
        issue(v, exp_res);
        finish_op(exp_res, hold);
    endtask

    initial begin
        #12;
        check("reset_done", 32'(done), 32'd0);
        check("reset_result", 32'(result), 32'd0);
        #10 rst_n = 1'b1;
        @(negedge clk);

        // Vectors written element 7 first, element 0 last.
        run_op({16'h0004, 16'h0008, 16'h0002, 16'h0009, 16'h0001, 16'h0007, 16'h0003, 16'h0005}, 16'h0001, 3);
        run_op({16'h0004, 16'h0003, 16'h0002, 16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h0001}, 16'h8000, 1);
        run_op({8{16'h1234}}, 16'h1234, 2);
        run_op({16'h0000, {7{16'h0010}}}, 16'h0000, 0);
        run_op({16'h0005, 16'h0006, 16'h7FFF, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'hFFFE}, 16'hFFFE, 0);
        run_op({8{16'h8000}}, 16'h8000, 1);

        // Abort mid-scan: start high for 4 edges then dropped; done must never rise.
        numbers = {16'h0004, 16'h0008, 16'h0002, 16'h0009, 16'h0001, 16'h0007, 16'h0003, 16'h0005};
        start   = 1'b1;
        repeat (4) @(posedge clk);
        #1 start = 1'b0;
        repeat (12) @(negedge clk);
        check("abort_done", 32'(done), 32'd0);
        check("abort_result", 32'(result), 32'h8000);

        // Reset pulse mid-scan with start held high through reset.
        numbers = {16'h0100, 16'h0200, 16'h0300, 16'h0050, 16'h0400, 16'h0500, 16'h0600, 16'h0700};
        start   = 1'b1;
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midreset_done", 32'(done), 32'd0);
        check("midreset_result", 32'(result), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        issue({16'h0100, 16'h0200, 16'h0300, 16'h0050, 16'h0400, 16'h0500, 16'h0600, 16'h0700}, 16'h0050);
        finish_op(16'h0050, 1);

        // Back-to-back with a single low-start cycle between the operations.
        run_op({16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'h0055, 16'h0066, 16'h0009, 16'h0077}, 16'h0009, 0);
        run_op({16'hFF00, 16'h0022, 16'h0033, 16'h0044, 16'h0055, 16'h0066, 16'h0009, 16'h0077}, 16'hFF00, 0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
